// File: rtl/logica_pipe.sv
// logica_pipe: two-stage valid/ready pipeline producing x=A, y=~A, z=mode-selected B/C logic,
// plus a saturating count of ones delivered on z.
module logica_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] z_ones
);
    localparam int PW = $clog2(WIDTH + 1);
    logic             s1_v;
    logic [WIDTH-1:0] s1_a, s1_b, s1_c;
    logic [1:0]       s1_mode;
    logic             s2_free, in_xfer, out_xfer;
    logic [WIDTH-1:0] z_d;
    logic [PW-1:0]    pop;
    logic [CNT_W:0]   sum;

    assign s2_free  = ~out_valid | out_ready;
    assign in_ready = ~s1_v | s2_free;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        z_d = s1_mode == 2'b00 ? s1_b & s1_c :
              s1_mode == 2'b01 ? s1_b | s1_c :
              s1_mode == 2'b10 ? s1_b ^ s1_c : ~(s1_b & s1_c);
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + PW'(z[i]);
        sum = {1'b0, z_ones} + (CNT_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_c    <= '0;
            s1_mode <= '0;
        end else if (in_xfer) begin
            s1_v    <= 1'b1;
            s1_a    <= a;
            s1_b    <= b;
            s1_c    <= c;
            s1_mode <= mode;
        end else if (s1_v & s2_free) begin
            s1_v <= 1'b0;
        end
    end

    // S2 only moves when its current result has left (or it was empty), keeping outputs stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
        end else if (s2_free) begin
            out_valid <= s1_v;
            if (s1_v) begin
                x <= s1_a;
                y <= ~s1_a;
                z <= z_d;
            end
        end
    end

    // clear wins over a same-cycle transfer; the extra MSB of sum flags overflow for saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            z_ones <= '0;
        else if (cnt_clr)
            z_ones <= '0;
        else if (out_xfer)
            z_ones <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_logica_pipe.sv
// tb_logica_pipe: vector table, directed stall/reset/saturation sequences and a randomized
// queue-based reference model for logica_pipe.
module tb_logica_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0;
    logic [1:0] mode = '0;
    logic       in_ready, out_valid;
    logic [7:0] x, y, z;
    logic [15:0] z_ones;
    logic       sat_in_ready, sat_out_valid;
    logic [7:0] sat_x, sat_y, sat_z;
    logic [3:0] sat_z_ones;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logica_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .z(z), .cnt_clr(cnt_clr), .z_ones(z_ones)
    );

    logica_pipe #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(sat_out_valid), .out_ready(out_ready),
        .x(sat_x), .y(sat_y), .z(sat_z), .cnt_clr(cnt_clr), .z_ones(sat_z_ones)
    );

    typedef struct {
        logic [7:0] a, b, c;
        logic [1:0] mode;
        logic [7:0] ex, ey, ez;
    } vec_t;

    typedef struct {
        logic [7:0] ex, ey, ez;
    } exp_t;

    vec_t v[8];
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] zf(input logic [7:0] bb, input logic [7:0] cc, input logic [1:0] m);
        case (m)
            2'd0: return bb & cc;
            2'd1: return bb | cc;
            2'd2: return bb ^ cc;
            default: return ~(bb & cc);
        endcase
    endfunction

    task automatic drive(input vec_t t);
        in_valid = 1'b1;
        a = t.a; b = t.b; c = t.c; mode = t.mode;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        a = '0; b = '0; c = '0; mode = '0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_z_ones", z_ones, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", in_ready, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ones;
        int m16, m4, p, cyc, sent, got;
        bit acc;
        exp_t e;
        v[0] = '{8'hF0, 8'hCC, 8'hAA, 2'd0, 8'hF0, 8'h0F, 8'h88};
        v[1] = '{8'h3C, 8'hCC, 8'hAA, 2'd1, 8'h3C, 8'hC3, 8'hEE};
        v[2] = '{8'h00, 8'hCC, 8'hAA, 2'd2, 8'h00, 8'hFF, 8'h66};
        v[3] = '{8'hFF, 8'hCC, 8'hAA, 2'd3, 8'hFF, 8'h00, 8'h77};
        v[4] = '{8'hA5, 8'h0F, 8'hFF, 2'd0, 8'hA5, 8'h5A, 8'h0F};
        v[5] = '{8'h12, 8'h00, 8'h00, 2'd3, 8'h12, 8'hED, 8'hFF};
        v[6] = '{8'h81, 8'hF0, 8'h0F, 2'd2, 8'h81, 8'h7E, 8'hFF};
        v[7] = '{8'h7E, 8'h00, 8'h00, 2'd1, 8'h7E, 8'h81, 8'h00};

        // back-to-back table beats: beat k visible at iteration k+2, counted at k+3
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k >= 2 && k - 2 < 8) begin
                chk("tbl_out_valid", out_valid, 1);
                chk("tbl_x", x, v[k-2].ex);
                chk("tbl_y", y, v[k-2].ey);
                chk("tbl_z", z, v[k-2].ez);
            end else begin
                chk("tbl_out_valid_idle", out_valid, 0);
            end
            exp_ones = 0;
            for (int j = 0; j <= k - 3; j++) exp_ones += $countones(v[j].ez);
            chk("tbl_z_ones", z_ones, exp_ones);
            if (k < 8) drive(v[k]); else in_valid = 1'b0;
            tick();
        end

        // stall with three beats offered
        reset_dut();
        drive(v[0]);
        tick();
        chk("stall_in_ready_one_full", in_ready, 1);
        drive(v[1]);
        tick();
        chk("stall_in_ready_full", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_x0", x, v[0].ex);
        drive(v[2]);
        tick();
        chk("stall_in_ready_hold", in_ready, 0);
        chk("stall_x_stable", x, v[0].ex);
        chk("stall_y_stable", y, v[0].ey);
        chk("stall_z_stable", z, v[0].ez);
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall_x1", x, v[1].ex);
        chk("stall_z1", z, v[1].ez);
        tick();
        chk("stall_x2", x, v[2].ex);
        chk("stall_z2", z, v[2].ez);
        tick();
        chk("stall_drained", out_valid, 0);
        chk("stall_z_ones", z_ones, 12);

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(v[3]);
        tick();
        drive(v[4]);
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_z", z, 0);
        chk("arst_z_ones", z_ones, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst_no_stale", out_valid, 0);
        end
        chk("arst_in_ready", in_ready, 1);

        // saturation on the 4-bit counter instance, then clear against a live transfer
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) chk("sat_8", sat_z_ones, 8);
            if (k == 4) chk("sat_15", sat_z_ones, 15);
            if (k == 5) begin
                chk("sat_hold_15", sat_z_ones, 15);
                chk("wide_24", z_ones, 24);
                chk("clr_with_xfer_valid", out_valid, 1);
            end
            if (k >= 6) begin
                chk("clr_sat", sat_z_ones, 0);
                chk("clr_wide", z_ones, 0);
            end
            cnt_clr = (k == 5);
            if (k < 4) begin
                in_valid = 1'b1; a = 8'h5A; b = 8'h00; c = 8'h00; mode = 2'd3;
            end else in_valid = 1'b0;
            tick();
        end
        cnt_clr = 1'b0;

        // randomized traffic against a queue-based reference model
        reset_dut();
        m16 = 0; m4 = 0; cyc = 0; sent = 0; got = 0; acc = 1'b0;
        while (got < 10000 && cyc < 60000) begin
            if (!in_valid || acc) begin
                if (sent < 10000 && $urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); mode = 2'($urandom);
                    sent++;
                end else in_valid = 1'b0;
            end
            out_ready = $urandom_range(0, 9) < 7;
            cnt_clr = $urandom_range(0, 499) == 0;
            @(negedge clk);
            chk("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
            acc = in_valid && in_ready;
            p = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_x", x, e.ex);
                    chk("rnd_y", y, e.ey);
                    chk("rnd_z", z, e.ez);
                    p = $countones(z);
                    got++;
                end
            end
            chk("rnd_z_ones", z_ones, m16);
            chk("rnd_sat_z_ones", sat_z_ones, m4);
            m16 = cnt_clr ? 0 : (m16 + p > 65535 ? 65535 : m16 + p);
            m4  = cnt_clr ? 0 : (m4 + p > 15 ? 15 : m4 + p);
            if (acc) q.push_back('{a, ~a, zf(b, c, mode)});
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("rnd_all_beats_out", got, 10000);
        chk("rnd_queue_empty", q.size(), 0);
        in_valid = 1'b0;
        cnt_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
